// File: rtl/boron_cbc_dec.sv
`default_nettype none
// boron_cbc_dec -- CBC-mode decryption wrapper sequencing an external block-decrypt core.
// Rev 1.0
module boron_cbc_dec #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] key,
  input  logic        iv_load,
  input  logic [63:0] iv,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        core_start,
  output logic [63:0] core_text,
  output logic [79:0] core_key,
  output logic        core_clr,
  input  logic        core_done,
  input  logic [63:0] core_result,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    CLEAR  = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [63:0] ct_reg;
  logic [63:0] chain_reg;
  logic [79:0] key_reg;
  logic [7:0]  wdog;
  logic        accept;
  logic        wait_tmo;

  // s_ready is qualified by rst so it drops the instant reset asserts.
  assign s_ready   = (state == IDLE) && rst;
  assign accept    = s_valid && s_ready;
  assign wait_tmo  = (state == WAIT) && !core_done && (wdog == WDOG_LAST);
  assign core_text = ct_reg;
  assign core_key  = key_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    core_clr   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done || wait_tmo) state_nxt = CLEAR;
      end
      CLEAR: begin
        core_clr  = 1'b1;
        state_nxt = m_valid ? OUT : IDLE;
      end
      OUT: begin
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ct_reg    <= '0;
      key_reg   <= '0;
      chain_reg <= '0;
      wdog      <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // An iv load coinciding with accept takes effect before this block chains.
          if (iv_load) begin
            chain_reg <= iv;
            err       <= 1'b0;
          end
          if (accept) begin
            ct_reg  <= s_data;
            key_reg <= key;
          end
        end
        LAUNCH: begin
          wdog <= '0;
        end
        WAIT: begin
          if (core_done) begin
            m_data    <= core_result ^ chain_reg;
            chain_reg <= ct_reg;
            m_valid   <= 1'b1;
          end else if (wdog == WDOG_LAST) begin
            err <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        OUT: begin
          if (m_ready) m_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
